// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings
// and the oversample divisor calculation used by both RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int DEFAULT_CLOCK_RATE = 100_000_000;
  localparam int DEFAULT_BAUD_RATE  = 9600;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // System clocks per oversample tick, floored.
  function automatic int calc_divisor(input int clock_rate, input int baud_rate,
                                      input int oversample);
    return clock_rate / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: counts system clocks 0..DIV-1 and pulses tick
// on the last count. Held at zero while clear is high.
module uart_tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled serial line to parallel bytes with a
// one-cycle valid strobe and a one-cycle framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = DEFAULT_CLOCK_RATE,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int DIV      = calc_divisor(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam logic [SAMPLE_W-1:0] HALF_LAST = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] FULL_LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: CLOCK_RATE / (BAUD_RATE*OVERSAMPLE) must be at least 2");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
    $error("uart_rx: DATA_BITS must be in 5..9");
  end

  logic                 rx_meta;
  logic                 rx_s;
  uart_state_e          state;
  uart_state_e          next_state;
  logic                 tick;
  logic [SAMPLE_W-1:0]  sample_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 shift_en;
  logic                 frame_ok;
  logic                 frame_bad;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  uart_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .clear  (state == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sampling happens mid start bit, then every full bit period after that.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) next_state = START;
      end
      START: begin
        if (tick && (sample_cnt == HALF_LAST)) next_state = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && (sample_cnt == FULL_LAST)) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) next_state = STOP;
        end
      end
      STOP: begin
        if (tick && (sample_cnt == FULL_LAST)) begin
          if (rx_s) begin
            frame_ok   = 1'b1;
            next_state = IDLE;
          end else begin
            frame_bad  = 1'b1;
            next_state = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      if (next_state != state) begin
        sample_cnt <= '0;
      end else if (tick) begin
        sample_cnt <= (sample_cnt == FULL_LAST) ? '0 : sample_cnt + 1'b1;
      end
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  // Output strobes and busy flag are registered so nothing reaches the
  // outputs combinationally from the serial line.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
      o_Rx_Byte   <= '0;
    end else begin
      o_Rx_DV     <= frame_ok;
      o_Frame_Err <= frame_bad;
      o_Busy      <= (next_state != IDLE);
      if (frame_ok) o_Rx_Byte <= shift_reg;
    end
  end

endmodule
